// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared encodings and helpers for the LSU memory controller.
package lsu_mem_ctrl_pkg;

    localparam int unsigned DefDataW = 32;
    localparam int unsigned DefAddrW = 32;

    typedef enum logic [1:0] {
        SzByte  = 2'b00,
        SzHalf  = 2'b01,
        SzWord  = 2'b10,
        SzDword = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StLdReq,
        StLdData,
        StStWr,
        StRmwRd,
        StRmwMrg,
        StRmwWr
    } state_e;

    // Misaligned access, or a dword access on a RAM narrower than 64 bits.
    function automatic logic access_err(input logic [1:0] size, input logic [2:0] addr_lo,
                                        input int unsigned data_w);
        case (size)
            SzByte:  return 1'b0;
            SzHalf:  return addr_lo[0];
            SzWord:  return addr_lo[1:0] != 2'd0;
            default: return (addr_lo != 3'd0) || (data_w < 32'd64);
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and RAM-side bundle for the LSU memory controller.
interface lsu_mem_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned LB = $clog2(NB);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [DATA_W-1:0] resp_rdata;
    logic              ram_en;
    logic              ram_we;
    logic [NB-1:0]     ram_be;
    logic [ADDR_W-LB-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdata, ram_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdata, ram_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  ram_en, ram_we, ram_be, ram_addr, ram_wdata
    );

endinterface

// File: rtl/lsu_mem_ctrl_mem_lane_align.sv
// Combinational lane steering: byte-enable mask, store replication, RMW merge
// and load extraction with sign/zero extension.
module lsu_mem_ctrl_mem_lane_align #(
    parameter int unsigned DATA_W = 32
) (
    input  logic [1:0]                   i_size,
    input  logic                         i_unsigned,
    input  logic [$clog2(DATA_W/8)-1:0]  i_lane,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W-1:0]            i_rdata,
    output logic [DATA_W/8-1:0]          o_be,
    output logic [DATA_W-1:0]            o_wdata_rep,
    output logic [DATA_W-1:0]            o_ld_data,
    output logic [DATA_W-1:0]            o_merged
);
    localparam int unsigned NB = DATA_W / 8;

    int unsigned       w_nbytes;
    int unsigned       w_lane;
    logic [DATA_W-1:0] w_shift;
    logic              w_msb;

    assign w_nbytes = 32'd1 << i_size;
    assign w_lane   = 32'(i_lane);
    assign w_shift  = i_rdata >> {i_lane, 3'b000};

    // Aligned accesses let a plain replication land the field on lanes k..k+size-1.
    always_comb begin
        o_be        = '0;
        o_wdata_rep = '0;
        o_merged    = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            o_be[k] = (k >= w_lane) && (k < w_lane + w_nbytes);
            o_wdata_rep[8*k +: 8] = i_wdata[8*(k & (w_nbytes - 1)) +: 8];
            o_merged[8*k +: 8] = o_be[k] ? o_wdata_rep[8*k +: 8] : i_rdata[8*k +: 8];
        end
    end

    always_comb begin
        w_msb     = 1'b0;
        o_ld_data = '0;
        for (int unsigned i = 0; i < DATA_W; i++) begin
            if (i == 8 * w_nbytes - 1) w_msb = w_shift[i];
        end
        for (int unsigned i = 0; i < DATA_W; i++) begin
            o_ld_data[i] = (i < 8 * w_nbytes) ? w_shift[i] : (w_msb & ~i_unsigned);
        end
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between EX/MEM and a 1-cycle synchronous data RAM.
// Holds the FSM, request latches and response registers; one request in flight.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned DATA_W      = DefDataW,
    parameter int unsigned ADDR_W      = DefAddrW,
    parameter bit          USE_BYTE_EN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    lsu_mem_ctrl_if.slave io_bus
);
    localparam int unsigned NB     = DATA_W / 8;
    localparam int unsigned LB     = $clog2(NB);
    localparam logic [1:0]  FullSz = 2'(LB);

    state_e            r_state;
    logic              r_uns;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_merged;
    logic              r_resp_valid;
    logic              r_resp_err;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_ram_en;
    logic              r_ram_we;

    logic [NB-1:0]     w_be;
    logic [DATA_W-1:0] w_wrep;
    logic [DATA_W-1:0] w_ld;
    logic [DATA_W-1:0] w_merged;
    logic              w_req_err;

    assign w_req_err = access_err(io_bus.req_type[1:0], io_bus.req_addr[2:0], DATA_W);

    lsu_mem_ctrl_mem_lane_align #(
        .DATA_W (DATA_W)
    ) u_align (
        .i_size      (r_size),
        .i_unsigned  (r_uns),
        .i_lane      (r_addr[LB-1:0]),
        .i_wdata     (r_wdata),
        .i_rdata     (io_bus.ram_rdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wrep),
        .o_ld_data   (w_ld),
        .o_merged    (w_merged)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StIdle;
            r_uns        <= 1'b0;
            r_size       <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_merged     <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_ram_en     <= 1'b0;
            r_ram_we     <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (io_bus.req_valid) begin
                        r_uns    <= io_bus.req_type[2];
                        r_size   <= io_bus.req_type[1:0];
                        r_addr   <= io_bus.req_addr;
                        r_wdata  <= io_bus.req_wdata;
                        // Full-width RMW stores write this directly, skipping the read.
                        r_merged <= io_bus.req_wdata;
                        if (w_req_err) begin
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                            r_resp_rdata <= '0;
                        end else if (!io_bus.req_we) begin
                            r_state  <= StLdReq;
                            r_ram_en <= 1'b1;
                        end else if (USE_BYTE_EN) begin
                            r_state  <= StStWr;
                            r_ram_en <= 1'b1;
                            r_ram_we <= 1'b1;
                        end else if (io_bus.req_type[1:0] == FullSz) begin
                            r_state  <= StRmwWr;
                            r_ram_en <= 1'b1;
                            r_ram_we <= 1'b1;
                        end else begin
                            r_state  <= StRmwRd;
                            r_ram_en <= 1'b1;
                        end
                    end
                end
                StLdReq:  r_state <= StLdData;
                StLdData: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_ld;
                end
                StRmwRd:  r_state <= StRmwMrg;
                StRmwMrg: begin
                    r_state  <= StRmwWr;
                    r_merged <= w_merged;
                    r_ram_en <= 1'b1;
                    r_ram_we <= 1'b1;
                end
                StStWr, StRmwWr: begin
                    r_state      <= StIdle;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= '0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign io_bus.req_ready  = (r_state == StIdle) && !i_rst;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_err   = r_resp_err;
    assign io_bus.resp_rdata = r_resp_rdata;
    // Gating with reset keeps an aborted write from reaching the RAM on the reset edge.
    assign io_bus.ram_en     = r_ram_en && !i_rst;
    assign io_bus.ram_we     = r_ram_we && !i_rst;
    assign io_bus.ram_addr   = r_addr[ADDR_W-1:LB];

    always_comb begin
        io_bus.ram_be    = '0;
        io_bus.ram_wdata = w_wrep;
        if (!i_rst && r_state == StStWr) begin
            io_bus.ram_be = w_be;
        end else if (!i_rst && r_state == StRmwWr) begin
            io_bus.ram_be    = '1;
            io_bus.ram_wdata = r_merged;
        end
    end

endmodule
